// File: rtl/uart_pkg.sv
// Shared types and constants for the boot-time UART program loader.
package uart_pkg;

  typedef enum logic [2:0] {
    LEN  = 3'd0,
    WORD = 3'd1,
    ACK  = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } loader_state_t;

  localparam logic [7:0] LOADER_ACK_DEFAULT  = 8'hAA;
  localparam int         UART_BYTES_PER_WORD = 4;

endpackage

// File: rtl/uart_loader_if.sv
// Loader-side bundle: UART rx/tx handshake and the imem write port.
interface uart_loader_if #(
  parameter int ADDR_W = 14
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ferr;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    input  rx_data, rx_valid, rx_ferr, tx_busy,
    output tx_data, tx_start, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output rx_data, rx_valid, rx_ferr, tx_busy,
    input  tx_data, tx_start, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/uart_loader.sv
// Single-shot boot loader: length-prefixed little-endian word stream from UART
// into imem, then one ACK byte and release of the core reset.
module uart_loader
  import uart_pkg::*;
#(
  parameter int         ADDR_W   = 14,
  parameter logic [7:0] ACK_BYTE = LOADER_ACK_DEFAULT
) (
  input  logic          clk,
  input  logic          rstn,
  uart_loader_if.master bus,
  output logic          cpu_rstn,
  output logic          done,
  output logic          err
);

  localparam logic [2:0]      S_LEN    = LEN;
  localparam logic [2:0]      S_WORD   = WORD;
  localparam logic [2:0]      S_ACK    = ACK;
  localparam logic [2:0]      S_DONE   = DONE;
  localparam logic [2:0]      S_ERR    = ERR;
  localparam logic [32:0]     CAPACITY = 33'd1 << ADDR_W;
  localparam logic [ADDR_W:0] WCNT_ONE = 1;
  localparam logic [1:0]      BCNT_LAST = 2'(UART_BYTES_PER_WORD - 1);

  logic [2:0]      state;
  logic [1:0]      bcnt;
  // Holds the bytes received so far; the lowest one falls out as the word completes.
  logic [23:0]     sr;
  logic [ADDR_W:0] wcnt;
  logic [ADDR_W:0] nwords;
  logic [31:0]     asm_word;
  logic            last_byte;

  assign asm_word  = {bus.rx_data, sr};
  assign last_byte = (bcnt == BCNT_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= S_LEN;
      bcnt           <= '0;
      sr             <= '0;
      wcnt           <= '0;
      nwords         <= '0;
      bus.tx_data    <= '0;
      bus.tx_start   <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      cpu_rstn       <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      bus.imem_we  <= 1'b0;
      bus.tx_start <= 1'b0;
      case (state)
        S_LEN: begin
          // A framing error discards any byte delivered alongside it.
          if (bus.rx_ferr) begin
            state <= S_ERR;
            err   <= 1'b1;
          end else if (bus.rx_valid) begin
            sr   <= asm_word[31:8];
            bcnt <= bcnt + 2'd1;
            if (last_byte) begin
              if ({1'b0, asm_word} > CAPACITY) begin
                state <= S_ERR;
                err   <= 1'b1;
              end else if (asm_word == 32'd0) begin
                state <= S_ACK;
              end else begin
                nwords <= asm_word[ADDR_W:0];
                wcnt   <= '0;
                state  <= S_WORD;
              end
            end
          end
        end
        S_WORD: begin
          if (bus.rx_ferr) begin
            state <= S_ERR;
            err   <= 1'b1;
          end else if (bus.rx_valid) begin
            sr   <= asm_word[31:8];
            bcnt <= bcnt + 2'd1;
            if (last_byte) begin
              bus.imem_we    <= 1'b1;
              bus.imem_addr  <= wcnt[ADDR_W-1:0];
              bus.imem_wdata <= asm_word;
              wcnt           <= wcnt + WCNT_ONE;
              if (wcnt + WCNT_ONE == nwords) state <= S_ACK;
            end
          end
        end
        S_ACK: begin
          if (!bus.tx_busy) begin
            bus.tx_start <= 1'b1;
            bus.tx_data  <= ACK_BYTE;
            state        <= S_DONE;
          end
        end
        S_DONE: begin
          // Lands one cycle after tx_start; rx traffic is ignored from here on.
          done     <= 1'b1;
          cpu_rstn <= 1'b1;
        end
        S_ERR: begin
          state <= S_ERR;
        end
        default: begin
          state <= S_ERR;
          err   <= 1'b1;
        end
      endcase
    end
  end

endmodule
